// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit CPU to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

  localparam int unsigned SRAM_DATA_W         = 16;
  localparam int unsigned SRAM_ADDR_W         = 18;
  localparam int unsigned WAIT_CNT_W          = 4;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    DONE
  } state_t;

  // Word index into the data window; wraps for addresses below the base.
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] address,
                                                        input logic [31:0] base);
    return (SRAM_ADDR_W-1)'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-halfword wait-state counter; terminal is high on the last cycle of an access.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: splits each 32-bit access into two 16-bit SRAM
// accesses of WAIT_CYCLES cycles each and stalls the pipeline via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                   state;
  logic                     req;
  logic                     wait_done;
  logic                     wait_clear;
  logic                     wait_en;
  logic                     lat_write;
  logic [SRAM_ADDR_W-2:0]   lat_word;
  logic [SRAM_DATA_W-1:0]   lat_wdata_hi;
  logic [SRAM_ADDR_W-2:0]   req_word;

  assign req      = wr_en || rd_en;
  assign req_word = word_index(address, BASE_ADDR);
  assign ready    = (state == DONE) || ((state == IDLE) && !req);

  // Counter restarts on entry to each half of the access.
  assign wait_en    = (state == ACC_LO) || (state == ACC_HI);
  assign wait_clear = ((state == IDLE) && req) || (wait_en && wait_done);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .enable  (wait_en),
    .terminal(wait_done)
  );

  // SRAM strobes are registered, so each is loaded on the edge entering its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      read_data    <= '0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_we_n    <= 1'b1;
      lat_write    <= 1'b0;
      lat_word     <= '0;
      lat_wdata_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state        <= ACC_LO;
            lat_write    <= wr_en;
            lat_word     <= req_word;
            lat_wdata_hi <= write_data[31:16];
            sram_addr    <= {req_word, 1'b0};
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
            end
          end
        end
        ACC_LO: begin
          if (wait_done) begin
            state     <= ACC_HI;
            sram_addr <= {lat_word, 1'b1};
            if (lat_write) begin
              sram_dq_out <= lat_wdata_hi;
            end else begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        ACC_HI: begin
          if (wait_done) begin
            state       <= DONE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            if (!lat_write) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
